// File: rtl/packet_buffer_reader_pkg.sv
// Shared constants and types for the packet buffer read client.
// Holds packet buffer geometry, BRAM read latency and the reader skid FIFO depth.
// No ports: imported by packet_buffer_reader and its testbench.
package packet_buffer_reader_pkg;

  localparam int BYTE_LEN                   = 8;
  localparam int PACKET_BUFFER_SIZE_LOG2    = 10;
  localparam int PACKET_BUFFER_READ_LATENCY = 2;
  localparam int PACKET_READER_FIFO_LOG2    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/packet_buffer_reader_fifo.sv
// Synchronous first-word-fall-through FIFO used as the reader's skid buffer.
// Latency: a push is visible at pop_data_o the cycle after it is written (head is a register read).
// Backpressure: pop is ignored while empty; push is ignored while full unless a pop frees a slot.
// Ports: push_i/push_data_i write side, pop_i/pop_data_o read side, full_o/empty_o/count_o status.
module stream_skid_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end

endmodule

// File: rtl/packet_buffer_reader.sv
// Reads a (start_addr, len) byte run out of the packet buffer and streams it out with a last flag.
// Latency: first out_valid_o READ_LATENCY+2 cycles after the start edge, then 1 byte/cycle.
// Backpressure: reads are credit-limited by skid FIFO space, so out_rdy_i=0 stalls issue without loss.
// Ports: start_i/start_addr_i/len_i command in, busy_o/done_o status, read_req_o/read_addr_o and
//        read_ready_i/read_data_i to the BRAM manager, out_valid_o/out_data_o/out_last_o/out_rdy_i stream.
module packet_buffer_reader
  import packet_buffer_reader_pkg::*;
#(
  parameter int RAM_SIZE_LOG2 = PACKET_BUFFER_SIZE_LOG2,
  parameter int READ_LATENCY  = PACKET_BUFFER_READ_LATENCY,
  parameter int FIFO_LOG2     = PACKET_READER_FIFO_LOG2
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_i,
  input  logic [RAM_SIZE_LOG2-1:0] start_addr_i,
  input  logic [RAM_SIZE_LOG2:0]   len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     read_req_o,
  output logic [RAM_SIZE_LOG2-1:0] read_addr_o,
  input  logic                     read_ready_i,
  input  logic [BYTE_LEN-1:0]      read_data_i,
  output logic                     out_valid_o,
  output logic [BYTE_LEN-1:0]      out_data_o,
  output logic                     out_last_o,
  input  logic                     out_rdy_i
);

  localparam int LW    = RAM_SIZE_LOG2 + 1;
  localparam int CW    = FIFO_LOG2 + 1;
  localparam int DEPTH = 2 ** FIFO_LOG2;

  // Full throughput needs room for every byte in flight plus the one being presented.
  if (DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("skid FIFO too shallow for the BRAM read latency");
  end

  rd_state_e               state_q, state_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           issued_q, issued_d;
  logic [LW-1:0]           out_cnt_q, out_cnt_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic                    read_req_q, read_req_d;
  logic [RAM_SIZE_LOG2-1:0] read_addr_q, read_addr_d;
  logic                    done_q, done_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count, fifo_count_nxt;
  logic [CW:0]             credit_used;

  // Returns arriving with nothing outstanding belong to a command killed by reset.
  assign fifo_push      = read_ready_i && (outstanding_q != '0);
  assign fifo_pop       = !fifo_empty && out_rdy_i;
  assign fifo_count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  stream_skid_fifo #(
    .WIDTH      (BYTE_LEN),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (fifo_push),
    .push_data_i (read_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (out_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issued_d      = issued_q + LW'(read_req_q);
    out_cnt_d     = out_cnt_q + LW'(fifo_pop);
    outstanding_d = outstanding_q + CW'(read_req_q) - CW'(fifo_push);
    read_addr_d   = read_addr_q + RAM_SIZE_LOG2'(read_req_q);
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            len_d       = len_i;
            issued_d    = '0;
            out_cnt_d   = '0;
            read_addr_d = start_addr_i;
          end
        end
      end
      ST_ISSUE: begin
        if (issued_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_pop && out_last_o) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Credit is judged on post-edge occupancy so a pop this cycle frees a slot immediately.
    credit_used = {1'b0, fifo_count_nxt} + {1'b0, outstanding_d};
    read_req_d  = (state_q == ST_ISSUE) && (state_d == ST_ISSUE) &&
                  (issued_d < len_q) && (credit_used < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      issued_q      <= '0;
      out_cnt_q     <= '0;
      outstanding_q <= '0;
      read_req_q    <= 1'b0;
      read_addr_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      out_cnt_q     <= out_cnt_d;
      outstanding_q <= outstanding_d;
      read_req_q    <= read_req_d;
      read_addr_q   <= read_addr_d;
      done_q        <= done_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign read_req_o  = read_req_q;
  assign read_addr_o = read_addr_q;
  assign out_valid_o = !fifo_empty;
  assign out_last_o  = !fifo_empty && (out_cnt_q == len_q - LW'(1));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
                                  !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_packet_buffer_reader.sv
module tb_packet_buffer_reader;
  import packet_buffer_reader_pkg::*;

  localparam int L     = PACKET_BUFFER_READ_LATENCY;
  localparam int AW    = PACKET_BUFFER_SIZE_LOG2;
  localparam int MSIZE = 2 ** AW;
  localparam int CRED  = 2 ** PACKET_READER_FIFO_LOG2;

  logic          clk = 1'b0;
  logic          reset_n, start, read_req, read_ready, busy, done;
  logic          out_valid, out_last, out_rdy;
  logic [AW-1:0] start_addr, read_addr;
  logic [AW:0]   len;
  logic [7:0]    read_data, out_data;

  always #5 clk = ~clk;

  packet_buffer_reader dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .read_req_o   (read_req),
    .read_addr_o  (read_addr),
    .read_ready_i (read_ready),
    .read_data_i  (read_data),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_rdy_i    (out_rdy)
  );

  // BRAM manager model: a request seen in cycle t returns mem[addr] in cycle t+L.
  // It ignores the reader's reset, so in-flight returns survive a reset as stale pulses.
  logic [7:0] mem [MSIZE];
  bit         sr_v [L];
  logic [7:0] sr_d [L];
  always @(posedge clk) begin
    sr_v[0] <= (read_req === 1'b1);
    sr_d[0] <= mem[read_addr];
    for (int i = 1; i < L; i++) begin
      sr_v[i] <= sr_v[i-1];
      sr_d[i] <= sr_d[i-1];
    end
  end
  assign read_ready = sr_v[L-1];
  assign read_data  = sr_d[L-1];

  int tests = 0, fails = 0;

  logic [7:0] got_q [$];
  bit         last_q [$];
  int         xfer_q [$];
  int         raddr_q [$];
  int         rcyc_q [$];
  int first_valid_c, done_c, last_xfer_c, busy_bad, unstable, credit_bad, timeout, extra, hold_reqs;

  // Drive one command starting at the current negedge; c counts cycles after the start edge.
  task automatic run_cmd(input int a, input int n, input int hold, input int pct,
                         input bit spurious, input int max_c);
    int c, reqs_before, pops_before, occ;
    bit prev_v, prev_r, rdy;
    logic [7:0] prev_d;
    got_q.delete(); last_q.delete(); xfer_q.delete(); raddr_q.delete(); rcyc_q.delete();
    first_valid_c = -1; done_c = -1; last_xfer_c = -1;
    busy_bad = 0; unstable = 0; credit_bad = 0; timeout = 0; extra = 0; hold_reqs = 0;
    reqs_before = 0; pops_before = 0; prev_v = 0; prev_r = 0; prev_d = '0;
    start = 1'b1; start_addr = AW'(a); len = (AW+1)'(n); out_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (done_c < 0 && c < max_c) begin
      occ = reqs_before - pops_before;
      if (read_req === 1'b1) begin
        raddr_q.push_back(int'(read_addr));
        rcyc_q.push_back(c);
        if (c < hold) hold_reqs++;
      end
      if (c == 0 || reqs_before >= n) begin
        if (read_req !== 1'b0) credit_bad++;
      end else if (read_req !== (occ < CRED)) begin
        credit_bad++;
      end
      if (prev_v && !prev_r && (out_valid !== 1'b1 || out_data !== prev_d)) unstable++;
      if (out_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
      if (done === 1'b1) begin
        done_c = c;
        if (busy !== 1'b0) busy_bad++;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        rdy = (c >= hold) && ($urandom_range(0, 99) < pct);
        out_rdy = rdy;
        if (out_valid === 1'b1 && rdy) begin
          got_q.push_back(out_data);
          last_q.push_back(out_last === 1'b1);
          xfer_q.push_back(c);
          last_xfer_c = c;
          pops_before++;
        end
        if (read_req === 1'b1) reqs_before++;
        if (spurious && (c == 2 || c == 5)) begin
          start = 1'b1; start_addr = AW'($urandom); len = (AW+1)'($urandom_range(1, 50));
        end else begin
          start = 1'b0;
        end
        prev_v = (out_valid === 1'b1); prev_r = rdy; prev_d = out_data;
        @(negedge clk);
        c++;
      end
    end
    if (done_c < 0) timeout = 1;
    out_rdy = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (read_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) extra++;
    end
  endtask

  function automatic int byte_errs(input int a, input int n);
    int e = 0;
    if (got_q.size() != n) e++;
    for (int i = 0; i < got_q.size() && i < n; i++)
      if (got_q[i] !== mem[(a + i) % MSIZE]) e++;
    return e;
  endfunction

  function automatic int last_errs(input int n);
    int e = 0;
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] != (i == n - 1)) e++;
    return e;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_status busy=%b done=%b expected 0 0", busy, done);
    end
    tests++;
    if (read_req !== 1'b0 || read_addr !== '0) begin
      fails++; $display("FAIL reset_read read_req=%b read_addr=%h expected 0 000", read_req, read_addr);
    end
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      fails++; $display("FAIL reset_stream out_valid=%b out_last=%b expected 0 0", out_valid, out_last);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bad = 0;
    run_cmd(32'h010, 4, 0, 100, 0, 100);
    tests++;
    if (timeout != 0) begin fails++; $display("FAIL basic_timeout got no done within budget"); end
    for (int i = 0; i < raddr_q.size(); i++)
      if (raddr_q[i] != 32'h010 + i || rcyc_q[i] != 1 + i) bad++;
    tests++;
    if (raddr_q.size() != 4 || bad != 0) begin
      fails++; $display("FAIL basic_reads count=%0d bad=%0d expected 4 consecutive reads 010..013", raddr_q.size(), bad);
    end
    tests++;
    if (first_valid_c != L + 2) begin
      fails++; $display("FAIL basic_latency first_valid=%0d expected %0d", first_valid_c, L + 2);
    end
    tests++;
    if (byte_errs(32'h010, 4) != 0 || last_errs(4) != 0) begin
      fails++; $display("FAIL basic_data byte_errs=%0d last_errs=%0d expected 0 0", byte_errs(32'h010, 4), last_errs(4));
    end
    tests++;
    if (done_c != 8 || last_xfer_c != 7) begin
      fails++; $display("FAIL basic_done done_c=%0d last_xfer=%0d expected 8 7", done_c, last_xfer_c);
    end
    tests++;
    if (busy_bad != 0 || extra != 0 || credit_bad != 0) begin
      fails++; $display("FAIL basic_ctrl busy_bad=%0d extra=%0d credit_bad=%0d expected 0", busy_bad, extra, credit_bad);
    end
  endtask

  task automatic test_zero_len;
    run_cmd(32'h055, 0, 0, 100, 0, 20);
    tests++;
    if (done_c != 0) begin fails++; $display("FAIL zero_done done_c=%0d expected 0", done_c); end
    tests++;
    if (raddr_q.size() != 0 || got_q.size() != 0) begin
      fails++; $display("FAIL zero_activity reads=%0d bytes=%0d expected 0 0", raddr_q.size(), got_q.size());
    end
    tests++;
    if (busy_bad != 0 || extra != 0) begin
      fails++; $display("FAIL zero_busy busy_bad=%0d extra=%0d expected 0 0", busy_bad, extra);
    end
  endtask

  task automatic test_wrap;
    int bad = 0;
    int a = MSIZE - 2;
    run_cmd(a, 4, 0, 100, 0, 100);
    for (int i = 0; i < raddr_q.size(); i++)
      if (raddr_q[i] != (a + i) % MSIZE) bad++;
    tests++;
    if (raddr_q.size() != 4 || bad != 0) begin
      fails++; $display("FAIL wrap_addr count=%0d bad=%0d expected %0d,%0d,0,1", raddr_q.size(), bad, MSIZE - 2, MSIZE - 1);
    end
    tests++;
    if (byte_errs(a, 4) != 0 || last_errs(4) != 0 || timeout != 0) begin
      fails++; $display("FAIL wrap_data byte_errs=%0d last_errs=%0d timeout=%0d expected 0", byte_errs(a, 4), last_errs(4), timeout);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    int a = $urandom_range(0, MSIZE - 1);
    run_cmd(a, 64, 20, 100, 0, 400);
    tests++;
    if (hold_reqs != CRED) begin
      fails++; $display("FAIL bp_credit reads_during_stall=%0d expected %0d", hold_reqs, CRED);
    end
    tests++;
    if (credit_bad != 0) begin fails++; $display("FAIL bp_issue_rule violations=%0d expected 0", credit_bad); end
    tests++;
    if (byte_errs(a, 64) != 0 || last_errs(64) != 0 || timeout != 0) begin
      fails++; $display("FAIL bp_data byte_errs=%0d last_errs=%0d timeout=%0d expected 0", byte_errs(a, 64), last_errs(64), timeout);
    end
    for (int i = 0; i < xfer_q.size(); i++) if (xfer_q[i] != 20 + i) bad++;
    tests++;
    if (bad != 0 || unstable != 0) begin
      fails++; $display("FAIL bp_rate gaps=%0d unstable=%0d expected 0 0", bad, unstable);
    end
  endtask

  task automatic test_random_rdy;
    int a = $urandom_range(0, MSIZE - 1);
    run_cmd(a, 200, 0, 50, 0, 3000);
    tests++;
    if (byte_errs(a, 200) != 0 || timeout != 0) begin
      fails++; $display("FAIL rand_data byte_errs=%0d timeout=%0d expected 0 0", byte_errs(a, 200), timeout);
    end
    tests++;
    if (unstable != 0 || last_errs(200) != 0) begin
      fails++; $display("FAIL rand_stable unstable=%0d last_errs=%0d expected 0 0", unstable, last_errs(200));
    end
    tests++;
    if (credit_bad != 0 || done_c != last_xfer_c + 1) begin
      fails++; $display("FAIL rand_ctrl credit_bad=%0d done_c=%0d expected 0 %0d", credit_bad, done_c, last_xfer_c + 1);
    end
  endtask

  task automatic test_busy_ignore;
    run_cmd(32'h300, 20, 0, 70, 1, 500);
    tests++;
    if (raddr_q.size() != 20 || byte_errs(32'h300, 20) != 0 || timeout != 0) begin
      fails++; $display("FAIL busy_ignore reads=%0d byte_errs=%0d expected 20 0", raddr_q.size(), byte_errs(32'h300, 20));
    end
    tests++;
    if (extra != 0 || busy_bad != 0) begin
      fails++; $display("FAIL busy_ignore_tail extra=%0d busy_bad=%0d expected 0 0", extra, busy_bad);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; start_addr = 10'h100; len = 11'd100; out_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || read_req !== 1'b0 || read_addr !== '0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_state busy=%b done=%b req=%b addr=%h valid=%b expected all 0",
                        busy, done, read_req, read_addr, out_valid);
    end
    reset_n = 1'b1;
    run_cmd(32'h200, 10, 0, 100, 0, 200);
    tests++;
    if (byte_errs(32'h200, 10) != 0 || last_errs(10) != 0 || timeout != 0) begin
      fails++; $display("FAIL midreset_stream byte_errs=%0d last_errs=%0d timeout=%0d expected 0",
                        byte_errs(32'h200, 10), last_errs(10), timeout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_random_rdy();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
